mem_bus_arbiter: RTL and testbench

Round-robin arbiter sharing the single external memory bus (address, data, read/write request, read/write done) between up to NREQ bus masters: the operand fetch/writeback manager, instruction fetch, and later DMA-style units. A master holds `req` for as long as it needs the bus. While granted, it issues any number of single-word read or write transactions. The arbiter forwards each transaction to memory, returns completion and read data, and times out transactions that memory never finishes.

---
 rtl/mem_bus_arbiter_if.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: per-master request/strobe/data lanes,
// per-master grant/done/error returns, and the shared external memory port.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requesters and models the memory.
interface mem_bus_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        rd_q;
  logic [NREQ-1:0]        wr_q;
  logic [NREQ*ADDR_W-1:0] addr_in;
  logic [NREQ*DATA_W-1:0] wdata_in;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        dn;
  logic [NREQ-1:0]        err;
  logic [DATA_W-1:0]      rdata;
  logic                   bus_busy;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   mem_read_dn;
  logic                   mem_write_dn;

  modport slave (
    input  req, rd_q, wr_q, addr_in, wdata_in,
    input  mem_rdata, mem_read_dn, mem_write_dn,
    output grant, dn, err, rdata, bus_busy,
    output mem_addr, mem_wdata, mem_read_q, mem_write_q
  );

  modport master (
    output req, rd_q, wr_q, addr_in, wdata_in,
    output mem_rdata, mem_read_dn, mem_write_dn,
    input  grant, dn, err, rdata, bus_busy,
    input  mem_addr, mem_wdata, mem_read_q, mem_write_q
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner arbitration for the shared external memory bus.
// The granted master keeps the bus until it drops req and may issue any number
// of single-word reads/writes; each is forwarded to memory and either
// completed (dn) or timed out (err) after MAX_WAIT cycles without a done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no owner; pick next requester round-robin after 'last'
// OWNED   | owner granted; accept its strobe or its release
// WAIT_RD | read issued to memory; waiting for mem_read_dn or timeout
// WAIT_WR | write issued to memory; waiting for mem_write_dn or timeout
//
// The interface instance must be built with the same NREQ/ADDR_W/DATA_W.
module mem_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int TMR_W = $clog2(MAX_WAIT + 1);
  // Timer value seen in the final allowed wait cycle.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     dn_q, dn_d;
  logic [NREQ-1:0]     err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                bus_busy_q, bus_busy_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic [ADDR_W-1:0]   addr_arr [NREQ];
  logic [DATA_W-1:0]   wdata_arr [NREQ];
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                rd_sel;
  logic                wr_sel;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.addr_in[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = bus.wdata_in[i*DATA_W +: DATA_W];
  end

  // Only the owner's strobes matter; everyone else is ignored silently.
  assign rd_sel = bus.rd_q[owner_q];
  assign wr_sel = bus.wr_q[owner_q];

  // Round-robin pick: scan last+1, last+2, ... (mod NREQ); the scan runs from
  // the far end so the nearest requester is the one left standing.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NREQ);
      if (bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and output computation; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    dn_d        = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    timer_d     = timer_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          state_d           = OWNED;
        end
      end

      OWNED: begin
        // Release wins over any strobe in the same cycle.
        if (!bus.req[owner_q]) begin
          grant_d = '0;
          last_d  = owner_q;
          state_d = IDLE;
        end else if (rd_sel && wr_sel) begin
          err_d[owner_q] = 1'b1;
        end else if (rd_sel) begin
          mem_addr_d = addr_arr[owner_q];
          mem_rd_d   = 1'b1;
          timer_d    = '0;
          state_d    = WAIT_RD;
        end else if (wr_sel) begin
          mem_addr_d  = addr_arr[owner_q];
          mem_wdata_d = wdata_arr[owner_q];
          mem_wr_d    = 1'b1;
          timer_d     = '0;
          state_d     = WAIT_WR;
        end
      end

      WAIT_RD: begin
        // A done in the last allowed cycle still counts as success.
        if (bus.mem_read_dn) begin
          rdata_d       = bus.mem_rdata;
          dn_d[owner_q] = 1'b1;
          state_d       = OWNED;
        end else if (timer_q == TMR_LAST) begin
          err_d[owner_q] = 1'b1;
          state_d        = OWNED;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      WAIT_WR: begin
        if (bus.mem_write_dn) begin
          dn_d[owner_q] = 1'b1;
          state_d       = OWNED;
        end else if (timer_q == TMR_LAST) begin
          err_d[owner_q] = 1'b1;
          state_d        = OWNED;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    bus_busy_d = |grant_d;
  end

  // State and output registers; synchronous reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NREQ - 1);
      owner_q     <= '0;
      grant_q     <= '0;
      dn_q        <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      bus_busy_q  <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      dn_q        <= dn_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      bus_busy_q  <= bus_busy_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.dn          = dn_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;
  assign bus.bus_busy    = bus_busy_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_read_q  = mem_rd_q;
  assign bus.mem_write_q = mem_wr_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a sequential driver plays requesters and memory,
// pushing every output event it expects (with the cycle it should appear in)
// onto a scoreboard queue; a negedge monitor pops and compares whenever the
// DUT shows a grant change, memory strobe, done or error.
module tb_mem_bus_arbiter;
  localparam int NREQ     = 4;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  localparam int EV_GNT = 0;
  localparam int EV_MRD = 1;
  localparam int EV_MWR = 2;
  localparam int EV_DN  = 3;
  localparam int EV_ERR = 4;

  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_BOTH = 2;

  typedef struct {
    int          kind;
    int          cyc;
    int          idx;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bif ();

  mem_bus_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  bit  mon_en = 1'b0;
  logic [NREQ-1:0] prev_gnt = '0;

  // reference model state
  int              m_owner = -1;
  int              m_last  = NREQ - 1;
  logic [31:0]     m_rdata = '0;
  logic [31:0]     m_addr  = '0;
  logic [31:0]     m_wdata = '0;
  logic [NREQ-1:0] req_v   = '0;

  function automatic string kname(input int k);
    case (k)
      EV_GNT:  return "grant";
      EV_MRD:  return "mem_read";
      EV_MWR:  return "mem_write";
      EV_DN:   return "dn";
      default: return "err";
    endcase
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic push(input int kind, input int c, input int idx,
                      input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int idx,
                         input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got idx=%0d a=%h d=%h at cyc %0d, required no event",
               kname(kind), idx, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.idx != idx || e.a !== a || e.d !== d) begin
        n_bad++;
        $display("FAIL event_%s: got %s cyc=%0d idx=%0d a=%h d=%h, required %s cyc=%0d idx=%0d a=%h d=%h",
                 kname(e.kind), kname(kind), cyc, idx, a, d,
                 kname(e.kind), e.cyc, e.idx, e.a, e.d);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // monitor: turn every visible output activity into an observed event
  always @(negedge clk) begin
    if (mon_en) begin
      if (bif.grant !== prev_gnt) begin
        observe(EV_GNT, int'(bif.grant), '0, '0);
        prev_gnt = bif.grant;
      end
      if (bif.mem_read_q)  observe(EV_MRD, 0, bif.mem_addr, bif.mem_wdata);
      if (bif.mem_write_q) observe(EV_MWR, 0, bif.mem_addr, bif.mem_wdata);
      for (int i = 0; i < NREQ; i++)
        if (bif.dn[i]) observe(EV_DN, i, bif.mem_addr, bif.rdata);
      for (int i = 0; i < NREQ; i++)
        if (bif.err[i]) observe(EV_ERR, i, bif.mem_addr, bif.rdata);
      n_cmp++;
      if (bif.bus_busy !== (|bif.grant)) begin
        n_bad++;
        $display("FAIL bus_busy: got %b, required %b at cyc %0d", bif.bus_busy, |bif.grant, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"},       64'(bif.grant),       64'd0);
    chk({tag, "_dn"},          64'(bif.dn),          64'd0);
    chk({tag, "_err"},         64'(bif.err),         64'd0);
    chk({tag, "_rdata"},       64'(bif.rdata),       64'd0);
    chk({tag, "_bus_busy"},    64'(bif.bus_busy),    64'd0);
    chk({tag, "_mem_addr"},    64'(bif.mem_addr),    64'd0);
    chk({tag, "_mem_wdata"},   64'(bif.mem_wdata),   64'd0);
    chk({tag, "_mem_read_q"},  64'(bif.mem_read_q),  64'd0);
    chk({tag, "_mem_write_q"}, 64'(bif.mem_write_q), 64'd0);
  endtask

  task automatic raise(input logic [NREQ-1:0] mask);
    int p;
    req_v   = req_v | mask;
    bif.req = req_v;
    if (m_owner < 0) begin
      p = rr_pick(m_last, req_v);
      if (p >= 0) begin
        push(EV_GNT, cyc + 1, 1 << p, '0, '0);
        m_owner = p;
      end
    end
    step();
  endtask

  task automatic release_bus(input bit same_strobe);
    int m, r, p;
    m        = m_owner;
    req_v[m] = 1'b0;
    bif.req  = req_v;
    if (same_strobe) bif.rd_q[m] = 1'b1;
    r = cyc + 1;
    push(EV_GNT, r, 0, '0, '0);
    m_last = m;
    p = rr_pick(m_last, req_v);
    if (p >= 0) push(EV_GNT, r + 1, 1 << p, '0, '0);
    step();
    bif.rd_q = '0;
    if (p >= 0) begin
      m_owner = p;
      step();
    end else begin
      m_owner = -1;
    end
  endtask

  // lat = cycles of memory silence after the strobe cycle; lat >= MAX_WAIT never answers
  task automatic xact(input int kind, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int lat, input bit distract,
                      input bit foreign_too);
    int m, s, nwait, dj, f;
    bit tmo;
    m = m_owner;
    bif.addr_in[m*AW +: AW]  = a;
    bif.wdata_in[m*DW +: DW] = wd;
    if (kind != K_WR) bif.rd_q[m] = 1'b1;
    if (kind != K_RD) bif.wr_q[m] = 1'b1;
    if (foreign_too) begin
      f = (m + int'($urandom_range(1, NREQ - 1))) % NREQ;
      bif.rd_q[f] = 1'b1;
    end
    s = cyc + 1;
    if (kind == K_BOTH) begin
      push(EV_ERR, s, m, m_addr, m_rdata);
    end else if (kind == K_RD) begin
      m_addr = a;
      push(EV_MRD, s, 0, a, m_wdata);
    end else begin
      m_addr  = a;
      m_wdata = wd;
      push(EV_MWR, s, 0, a, wd);
    end
    step();
    bif.rd_q = '0;
    bif.wr_q = '0;
    bif.addr_in[m*AW +: AW]  = $urandom;
    bif.wdata_in[m*DW +: DW] = $urandom;
    if (kind == K_BOTH) return;
    tmo   = (lat >= MAX_WAIT);
    nwait = tmo ? MAX_WAIT : lat;
    dj    = distract ? int'($urandom_range(0, nwait)) : -1;
    if (tmo) push(EV_ERR, s + MAX_WAIT, m, m_addr, m_rdata);
    for (int i = 0; i < nwait; i++) begin
      if (i == dj) begin
        if (kind == K_RD) begin
          bif.mem_write_dn = 1'b1;
        end else begin
          bif.mem_read_dn = 1'b1;
          bif.mem_rdata   = $urandom;
        end
      end
      step();
      bif.mem_read_dn  = 1'b0;
      bif.mem_write_dn = 1'b0;
    end
    if (!tmo) begin
      if (kind == K_RD) begin
        bif.mem_read_dn = 1'b1;
        bif.mem_rdata   = rd;
        m_rdata         = rd;
      end else begin
        bif.mem_write_dn = 1'b1;
        bif.mem_rdata    = $urandom;
      end
      push(EV_DN, s + nwait + 1, m, m_addr, m_rdata);
      step();
      bif.mem_read_dn  = 1'b0;
      bif.mem_write_dn = 1'b0;
    end
  endtask

  task automatic foreign();
    int f;
    if (m_owner < 0) f = int'($urandom_range(0, NREQ - 1));
    else             f = (m_owner + int'($urandom_range(1, NREQ - 1))) % NREQ;
    bif.addr_in[f*AW +: AW] = $urandom;
    case ($urandom_range(0, 2))
      0:       bif.rd_q[f] = 1'b1;
      1:       bif.wr_q[f] = 1'b1;
      default: begin bif.rd_q[f] = 1'b1; bif.wr_q[f] = 1'b1; end
    endcase
    step();
    bif.rd_q = '0;
    bif.wr_q = '0;
  endtask

  task automatic reset_mid_read(input logic [31:0] a);
    int m;
    m = m_owner;
    bif.addr_in[m*AW +: AW] = a;
    bif.rd_q[m] = 1'b1;
    m_addr = a;
    push(EV_MRD, cyc + 1, 0, a, m_wdata);
    step();
    bif.rd_q = '0;
    step();
    rst     = 1'b1;
    req_v   = '0;
    bif.req = req_v;
    push(EV_GNT, cyc + 1, 0, '0, '0);
    step();
    rst     = 1'b0;
    m_owner = -1;
    m_last  = NREQ - 1;
    m_rdata = '0;
    m_addr  = '0;
    m_wdata = '0;
    check_reset_vals("mid_rst");
    bif.mem_read_dn = 1'b1;
    bif.mem_rdata   = 32'hDEAD_BEEF;
    step();
    bif.mem_read_dn = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int op;
    bif.req          = '0;
    bif.rd_q         = '0;
    bif.wr_q         = '0;
    bif.addr_in      = '0;
    bif.wdata_in     = '0;
    bif.mem_rdata    = '0;
    bif.mem_read_dn  = 1'b0;
    bif.mem_write_dn = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_reset_vals("por");
    rst    = 1'b0;
    mon_en = 1'b1;

    // round-robin with all four requesting, one write each
    raise(4'b1111);
    for (int i = 0; i < NREQ; i++) begin
      xact(K_WR, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), '0, 1, 1'b0, 1'b0);
      release_bus(1'b0);
    end
    raise(4'b0001);

    // single read from master 0
    xact(K_RD, 32'h40, 32'h0, 32'h1234, 3, 1'b0, 1'b0);
    release_bus(1'b0);

    // locked burst by master 2 while master 1 waits
    raise(4'b0100);
    raise(4'b0010);
    xact(K_RD, 32'h0, 32'h0, 32'h1111_0000, 0, 1'b0, 1'b0);
    xact(K_RD, 32'h4, 32'h0, 32'h2222_0000, 1, 1'b1, 1'b0);
    xact(K_RD, 32'h8, 32'h0, 32'h3333_0000, 2, 1'b0, 1'b1);
    release_bus(1'b0);
    release_bus(1'b0);

    // timeout on a write, then a normal read
    raise(4'b1000);
    xact(K_WR, 32'h200, 32'hCAFE_F00D, '0, MAX_WAIT, 1'b0, 1'b0);
    xact(K_RD, 32'h204, 32'h0, 32'h5A5A_A5A5, MAX_WAIT - 1, 1'b0, 1'b0);

    // illegal double strobe, foreign strobe, release with same-cycle strobe
    xact(K_BOTH, 32'h300, 32'h1, '0, 0, 1'b0, 1'b0);
    foreign();
    release_bus(1'b1);

    // reset while a read is outstanding
    raise(4'b0001);
    reset_mid_read(32'h80);

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      if (m_owner < 0) begin
        raise(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
      end else begin
        op = int'($urandom_range(0, 11));
        if (op <= 4)
          xact((op % 2 == 0) ? K_RD : K_WR, $urandom, $urandom, $urandom,
               int'($urandom_range(0, MAX_WAIT)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
        else if (op == 5) xact(K_BOTH, $urandom, $urandom, '0, 0, 1'b0, 1'b0);
        else if (op == 6) foreign();
        else if (op == 7) raise(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
        else if (op <= 9) release_bus(1'($urandom_range(0, 1)));
        else step();
      end
    end

    repeat (10) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
